i2c_bit_engine: RTL and testbench
=================================

# i2c_bit_engine

Byte-level I2C bus engine sitting directly downstream of the I2C clock generator in `i2c_master`. It consumes a quarter-bit tick strobe, executes one bus command at a time (START, STOP, WRITE byte, READ byte), and drives open-drain SCL/SDA enables. Every command returns a response with the sampled ACK, read data, or error. Clock stretching by the slave is honoured, bounded by a timeout.

## Interface
- `STRETCH_MAX`, default 1024: maximum ticks to wait for SCL to rise while stretched before aborting.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tick`  in  1  one-cycle strobe at 4×I2C_FREQ (quarter-bit period) from the clock generator.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  engine idle; command accepted when `cmd_valid && cmd_ready`.
- `cmd_op`  in  3  0=START, 1=STOP, 2=WRITE, 3=READ; 4-7 invalid.
- `cmd_data`  in  8  byte to transmit (WRITE).
- `cmd_ack`  in  1  ACK bit the master sends after READ (0=ACK, 1=NACK).
- `rsp_valid`  out  1  one-cycle pulse, command complete.
- `rsp_data`  out  8  byte received (READ); held until the next response.
- `rsp_ack`  out  1  SDA sampled in the 9th bit of WRITE (0=slave ACK).
- `rsp_err`  out  1  stretch timeout or invalid op.
- `busy`  out  1  command in progress (inverse of `cmd_ready`).
- `scl_i`, `sda_i`  in  1 each  bus line levels, already synchronised to `clk`.
- `scl_oe`, `sda_oe`  out  1 each  1 = pull line low, 0 = release.

## Operation
- States: IDLE, START, STOP, WRITE, READ, DONE. In IDLE `cmd_ready`=1. On accept, latch op/data/ack and go to the op state. Invalid op goes straight to DONE with `rsp_err`=1 and no bus activity.
- Each bit is 4 quarters, q0..q3. The quarter counter advances only on `tick`.
- Data bit (WRITE/READ):
  - q0: `scl_oe`=1; SDA set to the bit.
  - q1: `scl_oe`=1.
  - q2: `scl_oe`=0.
  - q3: `scl_oe`=0; `sda_i` is sampled on the tick that leaves q3.
- START:
  - q0: `sda_oe`=0; SCL held as before.
  - q1: `scl_oe`=0.
  - q2: `sda_oe`=1, SCL high.
  - q3: `sda_oe`=1, `scl_oe`=1.
  - Also valid as a repeated START while SCL is held low.
- STOP:
  - q0: `scl_oe`=1, `sda_oe`=1.
  - q1: `scl_oe`=0.
  - q2: SDA still low.
  - q3: `sda_oe`=0.
  - Ends with both lines released.
- WRITE: 9 bits.
  - Bits 0-7: `cmd_data` MSB first, `sda_oe` = ~bit.
  - Bit 8: SDA released; the sample goes to `rsp_ack`.
- READ: 9 bits.
  - Bits 0-7: SDA released; samples shift into `rsp_data` MSB first.
  - Bit 8: `sda_oe` = ~`cmd_ack`.
- After a data command ends, SCL stays held low (`scl_oe`=1) until the next command.
- Clock stretching: in every quarter with SCL released, a tick does not advance the quarter unless `scl_i`=1.
  - Consecutive ticks spent waiting are counted.
  - When the count reaches `STRETCH_MAX`: release both lines, go to DONE with `rsp_err`=1, then IDLE.
- DONE lasts one cycle: `rsp_valid`=1, then IDLE.
- No arbitration check: `sda_i` is ignored while SDA is driven.
- Widths: quarter 2 bits, bit index 4 bits (0..8), stretch counter `$clog2(STRETCH_MAX+1)` bits, saturating.

## Timing
- Reset values:
  - `scl_oe`=0, `sda_oe`=0.
  - `cmd_ready`=1, `busy`=0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_ack`=0, `rsp_err`=0.
  - State IDLE; all counters 0.
- Reset mid-command releases both lines immediately (asynchronous). No response is issued.
- A tick in the accept cycle is ignored. q0 begins on the first tick strictly after accept.
- Duration without stretching: START/STOP 4 ticks, WRITE/READ 36 ticks.
- `rsp_valid` rises the cycle after the tick that ends the last quarter (DONE).
- `cmd_ready` rises the cycle after DONE. Accept-to-response is therefore N ticks + 1 cycle.
- `rsp_data`, `rsp_ack` and `rsp_err` update with `rsp_valid` and hold until the next response.
- `rsp_err` is cleared on non-error responses.
- `cmd_valid` while busy is ignored, not queued.
- `tick` in IDLE or DONE has no effect.

## Test plan
- Reset with tick running → `scl_oe`=`sda_oe`=0, `cmd_ready`=1, no `rsp_valid` for 100 ticks.
- START, then WRITE 0xA5 with slave pulling SDA low in bit 8, then STOP:
  - SDA pattern on SCL rising is 1,0,1,0,0,1,0,1.
  - Response `rsp_ack`=0, `rsp_err`=0.
  - Each of START/STOP takes 4 ticks; WRITE takes 36.
- WRITE 0x3C with SDA left high in bit 8 → `rsp_ack`=1.
- READ with slave driving 0x5E and `cmd_ack`=1:
  - `rsp_data`=0x5E.
  - `sda_oe`=0 through the 9th bit (NACK).
  - With `cmd_ack`=0, `sda_oe`=1 in bit 8.
- Slave holds `scl_i`=0 for 10 ticks at bit 3 of a WRITE → completion delayed by exactly 10 ticks; no error.
- With `STRETCH_MAX`=16, `scl_i` stuck low:
  - `rsp_err`=1 after 16 waiting ticks.
  - Both lines released.
- Separately, `cmd_op`=5 → `rsp_err`=1 one cycle after accept, with no bus toggling.

Source files
------------

// File: rtl/i2c_bit_engine.sv
// i2c_bit_engine: byte-level I2C bus engine executing START/STOP/WRITE/READ on
// quarter-bit ticks, driving open-drain enables and honouring clock stretching.
module i2c_bit_engine #(
    parameter int STRETCH_MAX = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic       cmd_ack,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_ack,
    output logic       rsp_err,
    output logic       busy,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe
);
    localparam int CW = $clog2(STRETCH_MAX + 1);
    typedef enum logic [2:0] {IDLE, START, STOP, WRITE, READ, DONE} state_t;
    state_t        state;
    logic [1:0]    q, nq;
    logic [3:0]    bit_idx, nb;
    logic [7:0]    shreg, sh_n;
    logic          ack, dat_sda, nscl, nsda, last, waiting;
    logic [CW-1:0] wait_cnt;
    assign cmd_ready = (state == IDLE);
    assign busy      = ~cmd_ready;
    // One shift register serves both directions: tx bits leave at [7], rx bits enter at [0]
    always_comb begin
        sh_n    = (q == 2'd3 && bit_idx < 4'd8) ? {shreg[6:0], sda_i} : shreg;
        nq      = q + 2'd1;
        nb      = (q == 2'd3) ? bit_idx + 4'd1 : bit_idx;
        dat_sda = (nb == 4'd8) ? (state == READ && !ack) : (state == WRITE && !sh_n[7]);
        nscl    = (state == START) ? (nq == 2'd3) : (state == STOP) ? 1'b0 : (nq < 2'd2);
        nsda    = (state == START) ? (nq >= 2'd2) : (state == STOP) ? (nq != 2'd3) : dat_sda;
        last    = (q == 2'd3) && (state == START || state == STOP || bit_idx == 4'd8);
        waiting = tick && !scl_oe && !scl_i;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            q         <= 2'd0;
            bit_idx   <= 4'd0;
            shreg     <= 8'd0;
            ack       <= 1'b0;
            wait_cnt  <= '0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'd0;
            rsp_ack   <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    ack      <= cmd_ack;
                    shreg    <= cmd_data;
                    q        <= 2'd0;
                    bit_idx  <= 4'd0;
                    wait_cnt <= '0;
                    case (cmd_op)
                        3'd0: begin state <= START; sda_oe <= 1'b0; end
                        3'd1: begin state <= STOP; scl_oe <= 1'b1; sda_oe <= 1'b1; end
                        3'd2: begin state <= WRITE; scl_oe <= 1'b1; sda_oe <= ~cmd_data[7]; end
                        3'd3: begin state <= READ; scl_oe <= 1'b1; sda_oe <= 1'b0; end
                        default: begin state <= DONE; rsp_valid <= 1'b1; rsp_err <= 1'b1; end
                    endcase
                end
                DONE: state <= IDLE;
                default: if (waiting) begin
                    if (wait_cnt == CW'(STRETCH_MAX - 1)) begin
                        state     <= DONE;
                        wait_cnt  <= '0;
                        scl_oe    <= 1'b0;
                        sda_oe    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else
                        wait_cnt <= wait_cnt + 1'b1;
                end else if (tick) begin
                    wait_cnt <= '0;
                    shreg    <= sh_n;
                    if (last) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_ack   <= (state == WRITE) ? sda_i : rsp_ack;
                        rsp_data  <= (state == READ) ? shreg : rsp_data;
                        scl_oe    <= (state == WRITE || state == READ) ? 1'b1 : scl_oe;
                    end else begin
                        q       <= nq;
                        bit_idx <= nb;
                        scl_oe  <= nscl;
                        sda_oe  <= nsda;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_bit_engine.sv
// tb_i2c_bit_engine: directed checks of the I2C bit engine against a wired-AND bus
// with a scripted slave that can drive SDA bits and stretch SCL.
module tb_i2c_bit_engine;
    logic       clk, rst_n, tick;
    logic       cmd_valid, cmd_ready, cmd_ack;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data, rsp_data;
    logic       rsp_valid, rsp_ack, rsp_err, busy;
    logic       scl_oe, sda_oe, s_scl_low, s_sda_low;
    int         checks = 0, failures = 0;
    int         r_ticks, r_cycles, r_toggles, pulses;
    logic [8:0] r_cap;
    logic       r_oe_or, r_b8_and;

    i2c_bit_engine #(.STRETCH_MAX(16)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_ack(cmd_ack),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ack(rsp_ack), .rsp_err(rsp_err),
        .busy(busy),
        .scl_i(!scl_oe && !s_scl_low), .sda_i(!sda_oe && !s_sda_low),
        .scl_oe(scl_oe), .sda_oe(sda_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        logic [1:0] div;
        div  = 2'd0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            div  = div + 2'd1;
            tick = (div == 2'd3);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one command from idle; the slave drives pat[8-bit] on SDA (0 = pull low)
    // and holds SCL low while the tick count since accept lies in [hs, hs+hl).
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] data, input logic a,
                           input logic [8:0] pat, input int hs, input int hl);
        logic [1:0] prev_oe;
        logic       prev_scl, sl, sd;
        int         n, cyc, idx;
        @(negedge clk);
        cmd_op    = op;
        cmd_data  = data;
        cmd_ack   = a;
        cmd_valid = 1'b1;
        prev_oe   = {scl_oe, sda_oe};
        prev_scl  = !scl_oe && !s_scl_low;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        cyc = 1;
        r_cap = '0;
        r_oe_or = 1'b0;
        r_b8_and = 1'b1;
        r_toggles = 0;
        while (1) begin
            idx       = (n < 36) ? 8 - n / 4 : 8;
            s_scl_low = (n >= hs && n < hs + hl);
            s_sda_low = (op == 3'd2 || op == 3'd3) && n < 36 && !pat[idx];
            sl = !scl_oe && !s_scl_low;
            sd = !sda_oe && !s_sda_low;
            if ({scl_oe, sda_oe} != prev_oe) r_toggles++;
            prev_oe = {scl_oe, sda_oe};
            r_oe_or = r_oe_or | sda_oe;
            if (n >= 32 && n < 36) r_b8_and = r_b8_and & sda_oe;
            if (sl && !prev_scl) r_cap = {r_cap[7:0], sd};
            prev_scl = sl;
            if (rsp_valid) break;
            if (cyc > 4000) begin
                check("rsp_timeout", 32'(cyc), 32'd0);
                break;
            end
            @(posedge clk);
            if (tick) n++;
            cyc++;
            @(negedge clk);
        end
        r_ticks   = n;
        r_cycles  = cyc;
        s_scl_low = 1'b0;
        s_sda_low = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 3'd0;
        cmd_data = 8'd0;
        cmd_ack = 1'b0;
        s_scl_low = 1'b0;
        s_sda_low = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_scl_oe", scl_oe, 0);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp", {rsp_valid, rsp_data, rsp_ack, rsp_err}, 0);
        rst_n = 1'b1;
        pulses = 0;
        repeat (400) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("idle_rsp_pulses", pulses, 0);
        check("idle_lines", {scl_oe, sda_oe}, 0);
        check("idle_ready", cmd_ready, 1);

        run_cmd(3'd0, 8'h00, 1'b0, 9'h1FF, 0, 0);
        check("start_ticks", r_ticks, 4);
        check("start_err", rsp_err, 0);
        check("start_lines", {scl_oe, sda_oe}, 2'b11);
        run_cmd(3'd2, 8'hA5, 1'b0, 9'h1FE, 0, 0);
        check("wr_a5_ticks", r_ticks, 36);
        check("wr_a5_sda_bits", r_cap, 9'h14A);
        check("wr_a5_ack", rsp_ack, 0);
        check("wr_a5_err", rsp_err, 0);
        check("wr_a5_scl_held", scl_oe, 1);
        run_cmd(3'd1, 8'h00, 1'b0, 9'h1FF, 0, 0);
        check("stop_ticks", r_ticks, 4);
        check("stop_lines", {scl_oe, sda_oe}, 0);

        run_cmd(3'd0, 8'h00, 1'b0, 9'h1FF, 0, 0);
        run_cmd(3'd2, 8'h3C, 1'b0, 9'h1FF, 0, 0);
        check("wr_3c_nack", rsp_ack, 1);
        run_cmd(3'd3, 8'h00, 1'b1, {8'h5E, 1'b1}, 0, 0);
        check("rd_5e_data", rsp_data, 8'h5E);
        check("rd_5e_ticks", r_ticks, 36);
        check("rd_nack_sda_oe", r_oe_or, 0);
        run_cmd(3'd3, 8'h00, 1'b0, {8'h81, 1'b1}, 0, 0);
        check("rd_81_data", rsp_data, 8'h81);
        check("rd_ack_bit8_sda_oe", r_b8_and, 1);

        run_cmd(3'd2, 8'h55, 1'b0, 9'h1FF, 14, 10);
        check("stretch_ticks", r_ticks, 46);
        check("stretch_err", rsp_err, 0);
        run_cmd(3'd2, 8'h00, 1'b0, 9'h1FF, 0, 1000);
        check("timeout_ticks", r_ticks, 18);
        check("timeout_err", rsp_err, 1);
        check("timeout_lines", {scl_oe, sda_oe}, 0);
        run_cmd(3'd0, 8'h00, 1'b0, 9'h1FF, 0, 0);
        check("err_cleared", rsp_err, 0);

        run_cmd(3'd5, 8'hFF, 1'b0, 9'h1FF, 0, 0);
        check("inv_cycles", r_cycles, 1);
        check("inv_err", rsp_err, 1);
        check("inv_no_toggle", r_toggles, 0);
        check("inv_data_held", rsp_data, 8'h81);

        @(negedge clk);
        cmd_op = 3'd2;
        cmd_data = 8'h00;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("mid_busy", busy, 1);
        check("mid_lines", {scl_oe, sda_oe}, 2'b11);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_lines", {scl_oe, sda_oe}, 0);
        check("async_rst_ready", cmd_ready, 1);
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("async_rst_no_rsp", pulses, 0);
        rst_n = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
